// File: rtl/xcel_ctrl_if.sv
// MMIO bus between the CPU register decoder (master) and xcel_ctrl (slave).
// Read data returns one cycle after the read strobe.
interface xcel_ctrl_if;
    logic [3:0]  mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_rdata;

    modport master (
        output mmio_addr,
        output mmio_wdata,
        output mmio_we,
        output mmio_re,
        input  mmio_rdata
    );

    modport slave (
        input  mmio_addr,
        input  mmio_wdata,
        input  mmio_we,
        input  mmio_re,
        output mmio_rdata
    );
endinterface

// File: rtl/xcel_ctrl.sv
// Accelerator control/status block: MMIO register file, start/done sequencing,
// run-latency counter, completed-run counter and level completion interrupt.
module xcel_ctrl #(
    parameter int AXI_AWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    xcel_ctrl_if.slave            mmio,
    output logic                  xcel_start,
    input  logic                  xcel_done,
    input  logic                  xcel_idle,
    output logic [AXI_AWIDTH-1:0] cfg_ifm_addr,
    output logic [AXI_AWIDTH-1:0] cfg_wt_addr,
    output logic [AXI_AWIDTH-1:0] cfg_ofm_addr,
    output logic [15:0]           cfg_ifm_dim,
    output logic [15:0]           cfg_wt_dim,
    output logic                  irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_PULSE,
        ST_BUSY
    } state_t;

    state_t                state_q;
    logic                  start_q;
    logic [31:0]           cycles_q;
    logic [31:0]           runs_q;
    logic                  done_flag_q;
    logic                  err_q;
    logic                  irq_en_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rdata_d;
    logic [AXI_AWIDTH-1:0] addr_q [3];
    logic [15:0]           dim_q  [2];

    logic busy;
    logic ctrl_wr;
    logic start_req;
    logic clear_req;
    logic cfg_sel;
    logic cfg_wr;

    assign busy      = (state_q != ST_IDLE);
    assign ctrl_wr   = mmio.mmio_we && (mmio.mmio_addr == 4'd0);
    assign start_req = ctrl_wr && mmio.mmio_wdata[0];
    assign clear_req = ctrl_wr && mmio.mmio_wdata[2];
    assign cfg_sel   = (mmio.mmio_addr >= 4'd2) && (mmio.mmio_addr <= 4'd6);
    assign cfg_wr    = mmio.mmio_we && cfg_sel && !busy;

    // Configuration registers are frozen while a run is in flight.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_addr
            always_ff @(posedge clk) begin
                if (rst) begin
                    addr_q[gi] <= '0;
                end else if (cfg_wr && (mmio.mmio_addr == 4'(gi + 2))) begin
                    addr_q[gi] <= AXI_AWIDTH'(mmio.mmio_wdata);
                end
            end
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_dim
            always_ff @(posedge clk) begin
                if (rst) begin
                    dim_q[gi] <= '0;
                end else if (cfg_wr && (mmio.mmio_addr == 4'(gi + 5))) begin
                    dim_q[gi] <= mmio.mmio_wdata[15:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            cycles_q    <= '0;
            runs_q      <= '0;
            done_flag_q <= 1'b0;
            err_q       <= 1'b0;
            irq_en_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (ctrl_wr) begin
                irq_en_q <= mmio.mmio_wdata[1];
            end
            // Clear takes effect before any error or completion raised this cycle.
            if (clear_req) begin
                done_flag_q <= 1'b0;
                err_q       <= 1'b0;
            end
            if (busy && ((mmio.mmio_we && cfg_sel) || start_req)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        if (xcel_idle) begin
                            state_q <= ST_PULSE;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (xcel_idle) begin
                        state_q <= ST_PULSE;
                        start_q <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    cycles_q <= '0;
                    state_q  <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (cycles_q != 32'hFFFF_FFFF) begin
                        cycles_q <= cycles_q + 32'd1;
                    end
                    if (xcel_done) begin
                        state_q     <= ST_IDLE;
                        done_flag_q <= 1'b1;
                        runs_q      <= runs_q + 32'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        case (mmio.mmio_addr)
            4'd0:    rdata_d = {30'd0, irq_en_q, 1'b0};
            4'd1:    rdata_d = {28'd0, xcel_idle, err_q, done_flag_q, busy};
            4'd2:    rdata_d = 32'(addr_q[0]);
            4'd3:    rdata_d = 32'(addr_q[1]);
            4'd4:    rdata_d = 32'(addr_q[2]);
            4'd5:    rdata_d = {16'd0, dim_q[0]};
            4'd6:    rdata_d = {16'd0, dim_q[1]};
            4'd7:    rdata_d = cycles_q;
            4'd8:    rdata_d = runs_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (mmio.mmio_re) begin
            rdata_q <= rdata_d;
        end
    end

    assign mmio.mmio_rdata = rdata_q;
    assign xcel_start      = start_q;
    assign irq             = done_flag_q & irq_en_q;
    assign cfg_ifm_addr    = addr_q[0];
    assign cfg_wt_addr     = addr_q[1];
    assign cfg_ofm_addr    = addr_q[2];
    assign cfg_ifm_dim     = dim_q[0];
    assign cfg_wt_dim      = dim_q[1];

endmodule

// File: tb/tb_xcel_ctrl.sv
// Randomized bench for xcel_ctrl against a register/run-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_xcel_ctrl;

    logic        clk;
    logic        rst;
    logic        xcel_start;
    logic        xcel_done;
    logic        xcel_idle;
    logic [31:0] cfg_ifm_addr;
    logic [31:0] cfg_wt_addr;
    logic [31:0] cfg_ofm_addr;
    logic [15:0] cfg_ifm_dim;
    logic [15:0] cfg_wt_dim;
    logic        irq;

    xcel_ctrl_if bus ();

    xcel_ctrl #(.AXI_AWIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mmio         (bus),
        .xcel_start   (xcel_start),
        .xcel_done    (xcel_done),
        .xcel_idle    (xcel_idle),
        .cfg_ifm_addr (cfg_ifm_addr),
        .cfg_wt_addr  (cfg_wt_addr),
        .cfg_ofm_addr (cfg_ofm_addr),
        .cfg_ifm_dim  (cfg_ifm_dim),
        .cfg_wt_dim   (cfg_wt_dim),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int pulse_cnt = 0;
    int exp_pulses = 0;

    // Reference model: register contents and run bookkeeping
    logic [31:0] m_addr [3];
    logic [15:0] m_dim  [2];
    logic [31:0] m_cycles;
    logic [31:0] m_runs;
    bit          m_done;
    bit          m_err;
    bit          m_irq_en;

    always @(negedge clk) if (xcel_start === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_addr[i] = '0;
        for (int i = 0; i < 2; i++) m_dim[i] = '0;
        m_cycles = '0;
        m_runs   = '0;
        m_done   = 0;
        m_err    = 0;
        m_irq_en = 0;
    endtask

    function automatic logic [31:0] model_rd(input int off);
        case (off)
            0:       return {30'd0, m_irq_en, 1'b0};
            1:       return {28'd0, xcel_idle, m_err, m_done, 1'b0};
            2, 3, 4: return m_addr[off-2];
            5, 6:    return {16'd0, m_dim[off-5]};
            7:       return m_cycles;
            8:       return m_runs;
            default: return 32'd0;
        endcase
    endfunction

    task automatic mmio_write(input int off, input logic [31:0] data);
        @(negedge clk);
        bus.mmio_we    = 1'b1;
        bus.mmio_addr  = 4'(off);
        bus.mmio_wdata = data;
        @(negedge clk);
        bus.mmio_we    = 1'b0;
    endtask

    task automatic mmio_read(input int off, output logic [31:0] data);
        @(negedge clk);
        bus.mmio_re   = 1'b1;
        bus.mmio_addr = 4'(off);
        @(negedge clk);
        bus.mmio_re   = 1'b0;
        data = bus.mmio_rdata;
    endtask

    // Idle-time write to any non-CTRL offset, tracked by the model
    task automatic cfg_write(input int off, input logic [31:0] data);
        mmio_write(off, data);
        if (off >= 2 && off <= 4) m_addr[off-2] = data;
        else if (off == 5 || off == 6) m_dim[off-5] = data[15:0];
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cfg_ifm_addr"}, cfg_ifm_addr, m_addr[0]);
        check({tag, "_cfg_wt_addr"},  cfg_wt_addr,  m_addr[1]);
        check({tag, "_cfg_ofm_addr"}, cfg_ofm_addr, m_addr[2]);
        check({tag, "_cfg_ifm_dim"},  {16'd0, cfg_ifm_dim}, {16'd0, m_dim[0]});
        check({tag, "_cfg_wt_dim"},   {16'd0, cfg_wt_dim},  {16'd0, m_dim[1]});
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_done & m_irq_en});
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        for (int off = 0; off < 9; off++) begin
            mmio_read(off, d);
            check($sformatf("%s_rd%0d", tag, off), d, model_rd(off));
        end
        check_outputs(tag);
    endtask

    // One accelerator run: lat = BUSY cycles up to and including done,
    // dly = cycles xcel_idle stays low after the start write,
    // inject = 0 none, 1 config write while busy, 2 second start while busy.
    task automatic do_run(input int lat, input int dly, input bit clr, input bit ien, input int inject);
        logic [31:0] d;
        logic [31:0] before_cfg [3];
        int inj_off;
        for (int i = 0; i < 3; i++) before_cfg[i] = m_addr[i];
        xcel_idle = (dly == 0);
        if (clr) begin
            m_done = 0;
            m_err  = 0;
        end
        m_irq_en = ien;
        mmio_write(0, {29'd0, clr, ien, 1'b1});
        if (dly > 0) begin
            check("wait_no_start", {31'd0, xcel_start}, 32'd0);
            mmio_read(1, d);
            check("wait_status", d, {28'd0, 1'b0, m_err, m_done, 1'b1});
            for (int i = 0; i < dly; i++) begin
                check("wait_no_start", {31'd0, xcel_start}, 32'd0);
                @(negedge clk);
            end
            xcel_idle = 1'b1;
            check("wait_no_start", {31'd0, xcel_start}, 32'd0);
            @(negedge clk);
        end
        check("start_pulse", {31'd0, xcel_start}, 32'd1);
        xcel_done = 1'($urandom_range(0, 1));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            bus.mmio_we = 1'b0;
            if (k == 1) begin
                check("start_once", {31'd0, xcel_start}, 32'd0);
                if (inject == 1) begin
                    inj_off = $urandom_range(2, 6);
                    bus.mmio_we    = 1'b1;
                    bus.mmio_addr  = 4'(inj_off);
                    bus.mmio_wdata = $urandom;
                    m_err = 1;
                end else if (inject == 2) begin
                    bus.mmio_we    = 1'b1;
                    bus.mmio_addr  = 4'd0;
                    bus.mmio_wdata = {30'd0, ien, 1'b1};
                    m_err = 1;
                end
            end
            xcel_done = (k == lat);
        end
        @(negedge clk);
        bus.mmio_we = 1'b0;
        xcel_done   = 1'b0;
        m_done   = 1;
        m_runs   = m_runs + 1;
        m_cycles = lat;
        exp_pulses++;
        check("pulse_count", pulse_cnt, exp_pulses);
        check("cfg_stable", cfg_ofm_addr, before_cfg[2]);
        check_regs($sformatf("run_l%0d_d%0d_i%0d", lat, dly, inject));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [31:0] v;
        rst = 1'b1;
        xcel_done = 1'b0;
        xcel_idle = 1'b0;
        bus.mmio_we = 1'b0;
        bus.mmio_re = 1'b0;
        bus.mmio_addr = '0;
        bus.mmio_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_start", {31'd0, xcel_start}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", bus.mmio_rdata, 32'd0);
        rst = 1'b0;

        for (int off = 0; off < 16; off++) begin
            mmio_read(off, d);
            check($sformatf("rst_rd%0d", off), d, 32'd0);
        end
        check_outputs("rst");

        cfg_write(2, 32'h1000_0000);
        cfg_write(5, 32'h0001_0040);
        mmio_read(2, d);
        check("ifm_addr_rd", d, 32'h1000_0000);
        mmio_read(5, d);
        check("ifm_dim_rd", d, 32'h0000_0040);
        check("cfg_ifm_dim", {16'd0, cfg_ifm_dim}, 32'h0000_0040);

        // Basic run: CTRL=0x3, done 10 cycles after the pulse
        do_run(10, 0, 0, 1, 0);
        mmio_read(1, d);
        check("status_done", d, 32'h0000_000A);
        check("irq_done", {31'd0, irq}, 32'd1);
        mmio_write(0, 32'h4);
        m_done = 0; m_err = 0; m_irq_en = 0;
        check("irq_clr", {31'd0, irq}, 32'd0);
        mmio_read(1, d);
        check("status_clr", d, 32'h0000_0008);

        do_run(6, 5, 0, 1, 0);
        do_run(7, 0, 0, 0, 1);
        do_run(4, 3, 0, 1, 2);
        mmio_write(0, 32'h4);
        m_done = 0; m_err = 0; m_irq_en = 0;
        mmio_read(1, d);
        check("err_clr", d, 32'h0000_0008);

        // Read and write of the same offset in one cycle returns the old value
        v = $urandom;
        @(negedge clk);
        bus.mmio_we = 1'b1; bus.mmio_re = 1'b1;
        bus.mmio_addr = 4'd3; bus.mmio_wdata = v;
        @(negedge clk);
        bus.mmio_we = 1'b0; bus.mmio_re = 1'b0;
        check("rd_wr_same", bus.mmio_rdata, m_addr[1]);
        m_addr[1] = v;
        mmio_read(3, d);
        check("rd_after_wr", d, v);
        repeat (3) @(negedge clk);
        check("rdata_hold", bus.mmio_rdata, v);

        for (int it = 0; it < 20; it++) begin
            int off;
            for (int j = 0; j < 3; j++) begin
                off = $urandom_range(1, 15);
                cfg_write(off, $urandom);
                off = $urandom_range(0, 15);
                mmio_read(off, d);
                check($sformatf("rand_rd%0d", off), d, model_rd(off));
            end
            do_run($urandom_range(1, 20),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(3, 8) : 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2));
        end

        // Reset in the middle of a run
        xcel_idle = 1'b1;
        mmio_write(0, 32'h1);
        exp_pulses++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_rdata", bus.mmio_rdata, 32'd0);
        xcel_done = 1'b1;
        repeat (2) @(negedge clk);
        xcel_done = 1'b0;
        check_regs("midrst");
        check("midrst_pulses", pulse_cnt, exp_pulses);
        do_run(5, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
